instruction_fetch: RTL and testbench

Fetch stage of the datapath: owns the program counter, drives the address of the instruction memory, and captures the returned word into the IF/ID register for the decoder. It selects the next PC (sequential, branch, jump, jump-register), and supports stall and flush from the hazard logic. It stops fetching on a PC outside the text window.

---
 rtl/instruction_fetch.sv | 245 ++++++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction-memory address, fills the IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise fault.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter int unsigned TEXT_WORDS = 256
) (
  input  logic        clock_i,
  input  logic        clear_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jump_reg_i,
  input  logic [31:0] jump_reg_addr_i,
  input  logic [31:0] instr_in_i,
  output logic [31:0] pc_o,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o
);

  localparam logic [31:0] WIN_BYTES = 32'(TEXT_WORDS) << 2;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    IFID_HOLD    = 2'd0,
    IFID_BUBBLE  = 2'd1,
    IFID_CAPTURE = 2'd2
  } ifid_op_e;

  state_e      state_q, state_d;
  ifid_op_e    ifid_op_s;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_plus4_s;
  logic        in_window_s;
  logic        redirect_s;
  logic [31:0] target_raw_s;
  logic [31:0] target_s;
  logic        misaligned_s;

  assign pc_plus4_s  = pc_q + 32'd4;
  // Unsigned offset compare also catches PCs below TEXT_BASE (they wrap to huge offsets).
  assign in_window_s = ((pc_q - TEXT_BASE) < WIN_BYTES);
  assign redirect_s  = jump_reg_i | jump_i | branch_taken_i;

  // Redirect target selection, highest priority first.
  always_comb begin
    target_raw_s = pc_plus4_s;
    if (jump_reg_i) begin
      target_raw_s = jump_reg_addr_i;
    end else if (jump_i) begin
      target_raw_s = {ifpc4_q[31:28], jump_index_i, 2'b00};
    end else if (branch_taken_i) begin
      target_raw_s = branch_target_i;
    end else begin
      target_raw_s = pc_plus4_s;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic        fault_set_s;

  assign target_s     = target_raw_s;
  assign misaligned_s = redirect_s & (target_raw_s[1:0] != 2'b00);
  assign fault_set_s  = (state_q == S_RUN) & ~stall_i & in_window_s & misaligned_s;

  // Fault is sticky until clear; the address is captured once, on the cycle fetch halts.
  always_comb begin
    fault_d      = fault_q | fault_set_s;
    fault_addr_d = fault_addr_q;
    if (fault_set_s) begin
      fault_addr_d = target_s;
    end else begin
      fault_addr_d = fault_addr_q;
    end
  end

  // Fault register.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0000_0000;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;
`else
  assign target_s     = target_raw_s & 32'hFFFF_FFFC;
  assign misaligned_s = 1'b0;
  assign fault_o      = 1'b0;
  assign fault_addr_o = 32'h0000_0000;
`endif

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leaving the window or a bad redirect target stops fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (!stall_i && (!in_window_s || (redirect_s && misaligned_s))) begin
          state_d = S_HALT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // FSM outputs: next PC and IF/ID operation.
  always_comb begin
    pc_d      = pc_q;
    ifid_op_s = IFID_HOLD;
    case (state_q)
      S_RUN: begin
        if (stall_i) begin
          pc_d = pc_q;
          if (flush_i) begin
            ifid_op_s = IFID_BUBBLE;
          end else begin
            ifid_op_s = IFID_HOLD;
          end
        end else if (!in_window_s) begin
          pc_d      = pc_q;
          ifid_op_s = IFID_BUBBLE;
        end else if (redirect_s) begin
          ifid_op_s = IFID_BUBBLE;
          if (misaligned_s) begin
            pc_d = pc_q;
          end else begin
            pc_d = target_s;
          end
        end else begin
          pc_d = pc_plus4_s;
          if (flush_i) begin
            ifid_op_s = IFID_BUBBLE;
          end else begin
            ifid_op_s = IFID_CAPTURE;
          end
        end
      end
      S_HALT: begin
        pc_d      = pc_q;
        ifid_op_s = IFID_BUBBLE;
      end
      default: begin
        pc_d      = pc_q;
        ifid_op_s = IFID_BUBBLE;
      end
    endcase
  end

  // IF/ID next-state contents.
  always_comb begin
    valid_d  = valid_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    ifpc4_d  = ifpc4_q;
    halted_d = (state_d == S_HALT);
    case (ifid_op_s)
      IFID_HOLD: begin
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
      end
      IFID_BUBBLE: begin
        valid_d = 1'b0;
        instr_d = 32'h0000_0000;
        ifpc_d  = 32'h0000_0000;
        ifpc4_d = 32'h0000_0000;
      end
      IFID_CAPTURE: begin
        valid_d = 1'b1;
        instr_d = instr_in_i;
        ifpc_d  = pc_q;
        ifpc4_d = pc_plus4_s;
      end
      default: begin
        valid_d = 1'b0;
        instr_d = 32'h0000_0000;
        ifpc_d  = 32'h0000_0000;
        ifpc4_d = 32'h0000_0000;
      end
    endcase
  end

  // PC, IF/ID and halted registers.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0000_0000;
      ifpc_q   <= 32'h0000_0000;
      ifpc4_q  <= 32'h0000_0000;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      ifpc4_q  <= ifpc4_d;
      halted_q <= halted_d;
    end
  end

  assign pc_o          = pc_q;
  assign if_valid_o    = valid_q;
  assign if_instr_o    = instr_q;
  assign if_pc_o       = ifpc_q;
  assign if_pc_plus4_o = ifpc4_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues expected post-edge state,
// a negedge monitor pops and compares. Honours FETCH_ALIGN_CHECK_EN like the RTL.
module tb_instruction_fetch;

  localparam logic [31:0] B = 32'h0040_0000;

  logic        clk;
  logic        clear, stall, flush, br, jmp, jr;
  logic [31:0] br_tgt, jr_addr, instr_in;
  logic [25:0] jidx;
  logic [31:0] pc, if_instr, if_pc, if_pc4, fault_addr;
  logic        if_valid, halted, fault;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        h;
    logic        f;
    logic [31:0] fa;
  } exp_t;

  exp_t sb_q[$];
  logic        exp_f;
  logic [31:0] exp_fa;

  instruction_fetch dut (
    .clock_i        (clk),
    .clear_i        (clear),
    .stall_i        (stall),
    .flush_i        (flush),
    .branch_taken_i (br),
    .branch_target_i(br_tgt),
    .jump_i         (jmp),
    .jump_index_i   (jidx),
    .jump_reg_i     (jr),
    .jump_reg_addr_i(jr_addr),
    .instr_in_i     (instr_in),
    .pc_o           (pc),
    .if_valid_o     (if_valid),
    .if_instr_o     (if_instr),
    .if_pc_o        (if_pc),
    .if_pc_plus4_o  (if_pc4),
    .halted_o       (halted),
    .fault_o        (fault),
    .fault_addr_o   (fault_addr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign instr_in = mem_word(pc);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.nm, ".pc"},         pc,                 e.pc);
      chk({e.nm, ".if_valid"},   {31'd0, if_valid},  {31'd0, e.v});
      chk({e.nm, ".if_instr"},   if_instr,           e.instr);
      chk({e.nm, ".if_pc"},      if_pc,              e.ipc);
      chk({e.nm, ".if_pc4"},     if_pc4,             e.ipc4);
      chk({e.nm, ".halted"},     {31'd0, halted},    {31'd0, e.h});
      chk({e.nm, ".fault"},      {31'd0, fault},     {31'd0, e.f});
      chk({e.nm, ".fault_addr"}, fault_addr,         e.fa);
    end
  end

  task automatic idle_inputs();
    clear = 1'b0; stall = 1'b0; flush = 1'b0;
    br = 1'b0; br_tgt = 32'd0;
    jmp = 1'b0; jidx = 26'd0;
    jr = 1'b0; jr_addr = 32'd0;
  endtask

  // One clock: inputs already set by caller; expectation describes state after the edge.
  task automatic tick(input string nm, input logic [31:0] epc, input logic ev,
                      input logic [31:0] eipc, input logic eh);
    exp_t e;
    @(posedge clk);
    e.nm    = nm;
    e.pc    = epc;
    e.v     = ev;
    e.instr = ev ? mem_word(eipc) : 32'd0;
    e.ipc   = ev ? eipc : 32'd0;
    e.ipc4  = ev ? eipc + 32'd4 : 32'd0;
    e.h     = eh;
    e.f     = exp_f;
    e.fa    = exp_fa;
    sb_q.push_back(e);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    exp_f  = 1'b0;
    exp_fa = 32'd0;
    @(negedge clk);

    clear = 1'b1;
    tick("reset", B, 1'b0, 32'd0, 1'b0);
    for (int k = 1; k <= 4; k++) tick("seq", B + 32'(4 * k), 1'b1, B + 32'(4 * (k - 1)), 1'b0);

    br = 1'b1; br_tgt = B + 32'h100;
    tick("branch", B + 32'h100, 1'b0, 32'd0, 1'b0);
    tick("branch_tgt", B + 32'h104, 1'b1, B + 32'h100, 1'b0);

    jr = 1'b1; jr_addr = B + 32'h18; jmp = 1'b1; jidx = 26'h3; br = 1'b1; br_tgt = B + 32'h300;
    tick("jr_prio", B + 32'h18, 1'b0, 32'd0, 1'b0);
    tick("jr_tgt", B + 32'h1C, 1'b1, B + 32'h18, 1'b0);
    tick("seq2", B + 32'h20, 1'b1, B + 32'h1C, 1'b0);

    jmp = 1'b1; jidx = 26'h010_0040; br = 1'b1; br_tgt = B + 32'h300;
    tick("jump_prio", B + 32'h100, 1'b0, 32'd0, 1'b0);
    tick("jump_tgt", B + 32'h104, 1'b1, B + 32'h100, 1'b0);

    stall = 1'b1;
    tick("stall1", B + 32'h104, 1'b1, B + 32'h100, 1'b0);
    stall = 1'b1; flush = 1'b1;
    tick("stall_flush", B + 32'h104, 1'b0, 32'd0, 1'b0);
    stall = 1'b1; br = 1'b1; br_tgt = B + 32'h300;
    tick("stall_drop_br", B + 32'h104, 1'b0, 32'd0, 1'b0);
    tick("resume", B + 32'h108, 1'b1, B + 32'h104, 1'b0);

    flush = 1'b1;
    tick("flush", B + 32'h10C, 1'b0, 32'd0, 1'b0);
    tick("post_flush", B + 32'h110, 1'b1, B + 32'h10C, 1'b0);

    jr = 1'b1; jr_addr = B + 32'h102;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_f = 1'b1; exp_fa = B + 32'h102;
    tick("misalign_fault", B + 32'h110, 1'b0, 32'd0, 1'b1);
    br = 1'b1; br_tgt = B + 32'h200;
    tick("fault_hold", B + 32'h110, 1'b0, 32'd0, 1'b1);
    clear = 1'b1; exp_f = 1'b0; exp_fa = 32'd0;
    tick("fault_clear", B, 1'b0, 32'd0, 1'b0);
`else
    tick("misalign_forced", B + 32'h100, 1'b0, 32'd0, 1'b0);
    tick("misalign_tgt", B + 32'h104, 1'b1, B + 32'h100, 1'b0);
    clear = 1'b1;
    tick("clear_mid", B, 1'b0, 32'd0, 1'b0);
`endif

    for (int k = 1; k <= 256; k++) tick("win_run", B + 32'(4 * k), 1'b1, B + 32'(4 * (k - 1)), 1'b0);
    tick("win_halt", B + 32'h400, 1'b0, 32'd0, 1'b1);
    jr = 1'b1; jr_addr = B; br = 1'b1; br_tgt = B; flush = 1'b1;
    tick("halt_ignore", B + 32'h400, 1'b0, 32'd0, 1'b1);
    stall = 1'b1;
    tick("halt_stall", B + 32'h400, 1'b0, 32'd0, 1'b1);
    clear = 1'b1;
    tick("halt_clear", B, 1'b0, 32'd0, 1'b0);
    tick("restart", B + 32'h4, 1'b1, B, 1'b0);

    jr = 1'b1; jr_addr = 32'h003F_FFFC;
    tick("below_jr", 32'h003F_FFFC, 1'b0, 32'd0, 1'b0);
    tick("below_halt", 32'h003F_FFFC, 1'b0, 32'd0, 1'b1);
    clear = 1'b1;
    tick("final_clear", B, 1'b0, 32'd0, 1'b0);

    for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
